// File: rtl/graph_roll_raster.sv
// Piano-roll raster walker: follows the beam through the octave/drum track stack
// and registers a per-pixel region code plus track identity and tile coordinates.
module graph_roll_raster #(
    parameter int unsigned N_OCT     = 4,
    parameter int unsigned DRUM_KEYS = 8,
    parameter int unsigned OCT_W     = 8,
    parameter int unsigned KEY_W     = 80,
    parameter int unsigned BW_GAP    = 33,
    parameter int unsigned TILE_W    = 15,
    parameter int unsigned WHITE_H   = 11,
    parameter int unsigned BLACK_H   = 9,
    parameter int unsigned DRUM_H    = 7,
    parameter int unsigned CURSOR_X  = 199,
    parameter int unsigned CURSOR_W  = 3,
    parameter int unsigned WRAP      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_frame,
    input  logic                       new_row,
    input  logic                       new_col,
    input  logic [$clog2(N_OCT+1)-1:0] scroll_group,
    input  logic [$clog2(TILE_W)-1:0]  subtile_scroll,
    output logic [2:0]                 region,
    output logic [$clog2(N_OCT+1)-1:0] group,
    output logic [3:0]                 key,
    output logic                       is_black,
    output logic                       is_drum,
    output logic [3:0]                 row_in_track,
    output logic [7:0]                 tile_idx,
    output logic [$clog2(TILE_W)-1:0]  tile_x,
    output logic [9:0]                 x,
    output logic                       at_cursor
);
    localparam int unsigned GW         = $clog2(N_OCT + 1);
    localparam int unsigned TXW        = $clog2(TILE_W);
    localparam int unsigned LAST_GROUP = (DRUM_KEYS > 0) ? N_OCT : N_OCT - 1;
    localparam int unsigned CONTENT_X  = OCT_W + KEY_W;
    localparam int unsigned BLACK_X    = OCT_W + BW_GAP;
    localparam int unsigned X_MAX      = 1023;

    localparam logic [2:0] R_OCTAVE    = 3'd0;
    localparam logic [2:0] R_SEPARATOR = 3'd1;
    localparam logic [2:0] R_CONTENT   = 3'd2;
    localparam logic [2:0] R_WHITE_KEY = 3'd3;
    localparam logic [2:0] R_BLACK_KEY = 3'd4;
    localparam logic [2:0] R_DRUM_KEY  = 3'd5;
    localparam logic [2:0] R_BLANK     = 3'd6;

    logic [GW-1:0]  group_q, group_d;
    logic [3:0]     key_q, key_d;
    logic [3:0]     row_q, row_d;
    logic [9:0]     x_q, x_d;
    logic [7:0]     tile_idx_q, tile_idx_d;
    logic [TXW-1:0] tile_x_q, tile_x_d;
    logic           blank_q, blank_d;
    logic [2:0]     region_q, region_d;
    logic           is_black_q, is_black_d;
    logic           is_drum_q, is_drum_d;
    logic           at_cursor_q, at_cursor_d;
    int unsigned    last_key;

    function automatic logic black_key(input logic [3:0] k);
        return (k == 4'd1) || (k == 4'd3) || (k == 4'd6) || (k == 4'd8) || (k == 4'd10);
    endfunction

    function automatic logic drum_group(input logic [GW-1:0] g);
        return 32'(g) == N_OCT;
    endfunction

    function automatic int unsigned track_h(input logic [GW-1:0] g, input logic [3:0] k);
        if (drum_group(g)) return DRUM_H;
        if (black_key(k)) return BLACK_H;
        return WHITE_H;
    endfunction

    // Pixel classification from the (next) walker state.
    function automatic logic [2:0] decode(input logic blank, input logic [GW-1:0] g,
                                          input logic [3:0] k, input logic [3:0] r,
                                          input logic [9:0] xx);
        logic        drum;
        logic        blk;
        logic        prev_white;
        int unsigned xi;
        drum       = drum_group(g);
        blk        = !drum && black_key(k);
        prev_white = !drum && (k != 4'd0) && !black_key(4'(k - 4'd1));
        xi         = 32'(xx);
        if (blank) return R_BLANK;
        if (xi < OCT_W) return R_OCTAVE;
        if (r == 4'd0) begin
            if ((k == 4'd0) || (xi >= CONTENT_X)) return R_SEPARATOR;
            if (!drum && !blk && prev_white) return R_SEPARATOR;
        end
        if (xi >= CONTENT_X) return R_CONTENT;
        if (drum) return R_DRUM_KEY;
        if (blk && (xi >= BLACK_X)) return R_BLACK_KEY;
        return R_WHITE_KEY;
    endfunction

    // Strobe handling; rst acts as a frame restart at group 0.
    always_comb begin
        group_d    = group_q;
        key_d      = key_q;
        row_d      = row_q;
        x_d        = x_q;
        tile_idx_d = tile_idx_q;
        tile_x_d   = tile_x_q;
        blank_d    = blank_q;
        last_key   = drum_group(group_q) ? DRUM_KEYS - 32'd1 : 32'd11;

        if (rst || new_frame) begin
            group_d = '0;
            if (!rst) begin
                group_d = (32'(scroll_group) > LAST_GROUP) ? GW'(LAST_GROUP) : scroll_group;
            end
            key_d      = '0;
            row_d      = '0;
            x_d        = '0;
            tile_idx_d = '0;
            tile_x_d   = '0;
            blank_d    = 1'b0;
        end else if (new_row) begin
            x_d        = '0;
            tile_idx_d = '0;
            tile_x_d   = '0;
            if (!blank_q) begin
                if (32'(row_q) < track_h(group_q, key_q)) begin
                    row_d = row_q + 4'd1;
                end else begin
                    row_d = '0;
                    if (32'(key_q) < last_key) begin
                        key_d = key_q + 4'd1;
                    end else if (32'(group_q) < LAST_GROUP) begin
                        key_d   = '0;
                        group_d = group_q + GW'(1);
                    end else if (WRAP != 0) begin
                        key_d   = '0;
                        group_d = '0;
                    end else begin
                        blank_d = 1'b1;
                    end
                end
            end
        end else if (new_col && (32'(x_q) != X_MAX)) begin
            x_d = x_q + 10'd1;
            if ((32'(x_q) + 32'd1) == CONTENT_X) begin
                tile_x_d = (32'(subtile_scroll) >= TILE_W) ? '0 : subtile_scroll;
            end else if (32'(x_q) >= CONTENT_X) begin
                if (32'(tile_x_q) >= TILE_W - 1) begin
                    tile_x_d   = '0;
                    tile_idx_d = tile_idx_q + 8'd1;
                end else begin
                    tile_x_d = tile_x_q + TXW'(1);
                end
            end
        end

        region_d    = decode(blank_d, group_d, key_d, row_d, x_d);
        is_drum_d   = drum_group(group_d);
        is_black_d  = !is_drum_d && black_key(key_d);
        at_cursor_d = (32'(x_d) >= CURSOR_X) && (32'(x_d) < CURSOR_X + CURSOR_W) &&
                      ((region_d == R_CONTENT) || (region_d == R_SEPARATOR));
    end

    always_ff @(posedge clk) begin
        group_q     <= group_d;
        key_q       <= key_d;
        row_q       <= row_d;
        x_q         <= x_d;
        tile_idx_q  <= tile_idx_d;
        tile_x_q    <= tile_x_d;
        blank_q     <= blank_d;
        region_q    <= region_d;
        is_black_q  <= is_black_d;
        is_drum_q   <= is_drum_d;
        at_cursor_q <= at_cursor_d;
    end

    assign region       = region_q;
    assign group        = group_q;
    assign key          = key_q;
    assign is_black     = is_black_q;
    assign is_drum      = is_drum_q;
    assign row_in_track = row_q;
    assign tile_idx     = tile_idx_q;
    assign tile_x       = tile_x_q;
    assign x            = x_q;
    assign at_cursor    = at_cursor_q;
endmodule

// File: tb/tb_graph_roll_raster.sv
// Bench for graph_roll_raster: directed vector table, hand-built track walks and
// random strobes against a track-list reference model, for WRAP=0 and WRAP=1.
module tb_graph_roll_raster;
    localparam int N_OCT     = 4;
    localparam int DRUM_KEYS = 8;
    localparam int OCT_W     = 8;
    localparam int KEY_W     = 80;
    localparam int BW_GAP    = 33;
    localparam int TILE_W    = 15;
    localparam int WHITE_H   = 11;
    localparam int BLACK_H   = 9;
    localparam int DRUM_H    = 7;
    localparam int CURSOR_X  = 199;
    localparam int CURSOR_W  = 3;
    localparam int CX        = OCT_W + KEY_W;

    logic       clk = 1'b0;
    logic       rst = 1'b0, new_frame = 1'b0, new_row = 1'b0, new_col = 1'b0;
    logic [2:0] scroll_group = '0;
    logic [3:0] subtile_scroll = '0;

    logic [2:0] region_0, region_1, group_0, group_1;
    logic [3:0] key_0, key_1, row_0, row_1, tile_x_0, tile_x_1;
    logic       is_black_0, is_black_1, is_drum_0, is_drum_1, at_cursor_0, at_cursor_1;
    logic [7:0] tile_idx_0, tile_idx_1;
    logic [9:0] x_0, x_1;

    always #5 clk = ~clk;

    graph_roll_raster #(.WRAP(0)) dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .new_row(new_row), .new_col(new_col),
        .scroll_group(scroll_group), .subtile_scroll(subtile_scroll),
        .region(region_0), .group(group_0), .key(key_0), .is_black(is_black_0),
        .is_drum(is_drum_0), .row_in_track(row_0), .tile_idx(tile_idx_0),
        .tile_x(tile_x_0), .x(x_0), .at_cursor(at_cursor_0));

    graph_roll_raster #(.WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .new_frame(new_frame), .new_row(new_row), .new_col(new_col),
        .scroll_group(scroll_group), .subtile_scroll(subtile_scroll),
        .region(region_1), .group(group_1), .key(key_1), .is_black(is_black_1),
        .is_drum(is_drum_1), .row_in_track(row_1), .tile_idx(tile_idx_1),
        .tile_x(tile_x_1), .x(x_1), .at_cursor(at_cursor_1));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: flat list of tracks, a row counter since frame start and x.
    int trk_g[$], trk_k[$], trk_h[$], trk_s[$];
    int total_rows;
    int m_start, m_L, m_x, m_sub, m_cyc;

    function automatic bit is_blk(int k);
        return (k == 1) || (k == 3) || (k == 6) || (k == 8) || (k == 10);
    endfunction

    task automatic build_tracks();
        total_rows = 0;
        for (int g = 0; g <= N_OCT; g++) begin
            for (int k = 0; k < ((g == N_OCT) ? DRUM_KEYS : 12); k++) begin
                int h;
                h = (g == N_OCT) ? DRUM_H : (is_blk(k) ? BLACK_H : WHITE_H);
                trk_g.push_back(g);
                trk_k.push_back(k);
                trk_h.push_back(h);
                trk_s.push_back(total_rows);
                total_rows += h + 1;
            end
        end
    endtask

    function automatic int model_region(bit blank, int g, int k, int r, int xx);
        bit drm;
        bit blk;
        drm = (g == N_OCT);
        blk = !drm && is_blk(k);
        if (blank) return 6;
        if (xx < OCT_W) return 0;
        if (r == 0) begin
            if (k == 0 || xx >= CX) return 1;
            if (!drm && !blk && !is_blk(k - 1)) return 1;
        end
        if (xx >= CX) return 2;
        if (drm) return 5;
        if (blk && xx >= OCT_W + BW_GAP) return 4;
        return 3;
    endfunction

    task automatic check_dut(input string nm, input bit wrap, input logic [2:0] a_reg,
                             input logic [2:0] a_g, input logic [3:0] a_k, input logic a_blk,
                             input logic a_drm, input logic [3:0] a_row, input logic [7:0] a_ti,
                             input logic [3:0] a_tx, input logic [9:0] a_x, input logic a_cur);
        int p, g, k, r, e_reg, e_tx, e_ti, off;
        bit blank, e_blk, e_drm, e_cur, ok;
        p = trk_s[m_start * 12] + m_L;
        blank = 1'b0;
        if (p >= total_rows) begin
            if (wrap) p = p % total_rows;
            else blank = 1'b1;
        end
        g = 0; k = 0; r = 0;
        if (!blank) begin
            for (int i = 0; i < trk_g.size(); i++) begin
                if (p >= trk_s[i] && p <= trk_s[i] + trk_h[i]) begin
                    g = trk_g[i]; k = trk_k[i]; r = p - trk_s[i];
                end
            end
        end
        e_drm = (g == N_OCT);
        e_blk = !e_drm && is_blk(k);
        e_reg = model_region(blank, g, k, r, m_x);
        e_cur = (m_x >= CURSOR_X) && (m_x < CURSOR_X + CURSOR_W) && (e_reg == 1 || e_reg == 2);
        e_tx = 0; e_ti = 0;
        if (m_x >= CX) begin
            off  = m_sub + m_x - CX;
            e_tx = off % TILE_W;
            e_ti = (off / TILE_W) % 256;
        end
        ok = (a_reg === 3'(e_reg)) && (a_x === 10'(m_x)) && (a_cur === e_cur);
        if (!blank) begin
            ok = ok && (a_g === 3'(g)) && (a_k === 4'(k)) && (a_row === 4'(r)) &&
                 (a_blk === e_blk) && (a_drm === e_drm) && (a_tx === 4'(e_tx)) &&
                 (a_ti === 8'(e_ti));
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL model_%s cyc=%0d got reg=%0d g=%0d k=%0d row=%0d blk=%0d drm=%0d x=%0d tx=%0d ti=%0d cur=%0d want reg=%0d g=%0d k=%0d row=%0d blk=%0d drm=%0d x=%0d tx=%0d ti=%0d cur=%0d blank=%0d",
                     nm, m_cyc, a_reg, a_g, a_k, a_row, a_blk, a_drm, a_x, a_tx, a_ti, a_cur,
                     e_reg, g, k, r, e_blk, e_drm, m_x, e_tx, e_ti, e_cur, blank);
        end
    endtask

    task automatic step(input bit r, input bit nf, input bit nr, input bit nc,
                        input int sg, input int ss);
        rst = r; new_frame = nf; new_row = nr; new_col = nc;
        scroll_group = 3'(sg); subtile_scroll = 4'(ss);
        if (r || nf) begin
            m_start = r ? 0 : ((sg > N_OCT) ? N_OCT : sg);
            m_L = 0; m_x = 0;
        end else if (nr) begin
            m_L++; m_x = 0;
        end else if (nc && m_x < 1023) begin
            m_x++;
            if (m_x == CX) m_sub = (ss >= TILE_W) ? 0 : ss;
        end
        m_cyc++;
        @(negedge clk);
        check_dut("w0", 1'b0, region_0, group_0, key_0, is_black_0, is_drum_0, row_0,
                  tile_idx_0, tile_x_0, x_0, at_cursor_0);
        check_dut("w1", 1'b1, region_1, group_1, key_1, is_black_1, is_drum_1, row_1,
                  tile_idx_1, tile_x_1, x_1, at_cursor_1);
    endtask

    task automatic expect_eq(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        bit rs, nf, nr, nc;
        int n, sg;
        int e_reg, e_g, e_k, e_row, e_x, e_tx, e_ti;
        bit e_blk, e_drm, e_cur;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rs, bit nf, bit nr, bit nc, int n, int sg, int e_reg,
                                int e_g, int e_k, int e_row, int e_x, int e_tx, int e_ti,
                                bit e_blk, bit e_drm, bit e_cur);
        vec_t v;
        v.rs = rs; v.nf = nf; v.nr = nr; v.nc = nc; v.n = n; v.sg = sg;
        v.e_reg = e_reg; v.e_g = e_g; v.e_k = e_k; v.e_row = e_row; v.e_x = e_x;
        v.e_tx = e_tx; v.e_ti = e_ti; v.e_blk = e_blk; v.e_drm = e_drm; v.e_cur = e_cur;
        return v;
    endfunction

    initial begin
        m_start = 0; m_L = 0; m_x = 0; m_sub = 0; m_cyc = 0;
        build_tracks();

        //        rs nf nr nc  n   sg reg g  k  row x    tx  ti blk drm cur
        tv.push_back(mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8,   0, 1, 0, 0, 0, 8,    0,  0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 13,  0, 0, 0, 1, 1, 0,    0,  0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8,   0, 3, 0, 1, 1, 8,    0,  0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 32,  0, 3, 0, 1, 1, 40,   0,  0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1,   0, 4, 0, 1, 1, 41,   0,  0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 46,  0, 4, 0, 1, 1, 87,   0,  0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1,   0, 2, 0, 1, 1, 88,   14, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1,   0, 2, 0, 1, 1, 89,   0,  1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1,   0, 2, 0, 1, 1, 90,   1,  1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 108, 0, 2, 0, 1, 1, 198,  4,  8, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1,   0, 2, 0, 1, 1, 199,  5,  8, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 2,   0, 2, 0, 1, 1, 201,  7,  8, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 1,   0, 2, 0, 1, 1, 202,  8,  8, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 824, 0, 2, 0, 1, 1, 1023, 4, 63, 1, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 1,   0, 0, 0, 1, 2, 0,    0,  0, 1, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 1,   7, 0, 4, 0, 0, 0,    0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 8,   0, 1, 4, 0, 0, 8,    0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 1, 0, 1,   0, 0, 4, 0, 1, 0,    0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 8,   0, 5, 4, 0, 1, 8,    0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 80,  0, 2, 4, 0, 1, 88,   14, 0, 0, 1, 0));
        tv.push_back(mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 22,  0, 0, 0, 2, 0, 0,    0,  0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8,   0, 3, 0, 2, 0, 8,    0,  0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 80,  0, 1, 0, 2, 0, 88,   14, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 34,  0, 0, 0, 5, 0, 0,    0,  0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8,   0, 1, 0, 5, 0, 8,    0,  0, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            bit ok;
            for (int j = 0; j < tv[i].n; j++) step(tv[i].rs, tv[i].nf, tv[i].nr, tv[i].nc, tv[i].sg, 14);
            ok = (region_0 === 3'(tv[i].e_reg)) && (group_0 === 3'(tv[i].e_g)) &&
                 (key_0 === 4'(tv[i].e_k)) && (row_0 === 4'(tv[i].e_row)) &&
                 (x_0 === 10'(tv[i].e_x)) && (tile_x_0 === 4'(tv[i].e_tx)) &&
                 (tile_idx_0 === 8'(tv[i].e_ti)) && (is_black_0 === tv[i].e_blk) &&
                 (is_drum_0 === tv[i].e_drm) && (at_cursor_0 === tv[i].e_cur);
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL vec%0d got reg=%0d g=%0d k=%0d row=%0d x=%0d tx=%0d ti=%0d blk=%0d drm=%0d cur=%0d want reg=%0d g=%0d k=%0d row=%0d x=%0d tx=%0d ti=%0d blk=%0d drm=%0d cur=%0d",
                         i, region_0, group_0, key_0, row_0, x_0, tile_x_0, tile_idx_0,
                         is_black_0, is_drum_0, at_cursor_0, tv[i].e_reg, tv[i].e_g, tv[i].e_k,
                         tv[i].e_row, tv[i].e_x, tv[i].e_tx, tv[i].e_ti, tv[i].e_blk,
                         tv[i].e_drm, tv[i].e_cur);
            end
        end

        // Full walk from group 2 through the drum group, then blank / wrap.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 2, 0);
        expect_eq("walk_start_g0", int'(group_0), 2);
        expect_eq("walk_start_g1", int'(group_1), 2);
        repeat (268) step(0, 0, 1, 0, 0, 0);
        expect_eq("walk_drum_g", int'(group_0), 4);
        expect_eq("walk_drum_key", int'(key_0), 0);
        step(0, 0, 1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 1, 0, 0);
        expect_eq("walk_drum_region0", int'(region_0), 5);
        expect_eq("walk_drum_region1", int'(region_1), 5);
        repeat (62) step(0, 0, 1, 0, 0, 0);
        expect_eq("walk_last_key", int'(key_0), 7);
        expect_eq("walk_last_row", int'(row_0), 7);
        step(0, 0, 1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 1, 0, 0);
        expect_eq("walk_blank", int'(region_0), 6);
        expect_eq("wrap_sep", int'(region_1), 1);
        expect_eq("wrap_group", int'(group_1), 0);
        expect_eq("wrap_key", int'(key_1), 0);
        expect_eq("wrap_row", int'(row_1), 0);
        repeat (5) step(0, 0, 0, 0, 0, 0);
        expect_eq("blank_hold", int'(region_0), 6);
        step(0, 1, 0, 0, 2, 0);
        expect_eq("reframe_group", int'(group_0), 2);
        expect_eq("reframe_region", int'(region_0), 0);

        // Random strobes: long rows first (content/cursor), then short rows (walk ends).
        for (int i = 0; i < 30000; i++) begin
            int  prow;
            bit  r, nf, nr, nc;
            prow = (i < 15000) ? 300 : 3;
            r    = ($urandom_range(0, 19999) == 0);
            nf   = ($urandom_range(0, 3999) == 0);
            nr   = ($urandom_range(0, prow - 1) == 0);
            nc   = ($urandom_range(0, 7) != 0);
            step(r, nf, nr, nc, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
